// File: rtl/i2c_host_ctrl.sv
// Single-controller I2C host: turns START/STOP/WRITE/READ commands into open-drain SCL/SDA waveforms.
// Each step is four quarter phases of ClkDiv cycles; released-SCL phases wait out target clock stretching.
module i2c_host_ctrl #(
    parameter int ClkDiv = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_ack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_nack_o,
    output logic       bus_busy_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o
);
    localparam int CW = $clog2(ClkDiv) + 1;
    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

    state_t          r_state, w_state_n;
    logic [1:0]      r_q, w_q_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [3:0]      r_bit, w_bit_n;
    logic [1:0]      r_op, w_op_n;
    logic [7:0]      r_data, w_data_n;
    logic            r_ack, w_ack_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_sample, w_sample_n;
    logic            r_scl, w_scl_n;
    logic            r_sda, w_sda_n;
    logic            r_ready, w_ready_n;
    logic            r_rsp_vld, w_rsp_vld_n;
    logic [7:0]      r_rsp_data, w_rsp_data_n;
    logic            r_nack, w_nack_n;
    logic            r_busy, w_busy_n;
    logic            w_stretch, w_phase_end;

    // SDA level driven during bit i of a WRITE/READ
    function automatic logic bit_val(input logic [1:0] op, input logic [7:0] d,
                                     input logic ack, input logic [3:0] i);
        if (i >= 4'd8)
            return (op == OP_READ) ? !ack : 1'b1;
        return (op == OP_READ) ? 1'b1 : d[3'(4'd7 - i)];
    endfunction

    assign w_stretch   = r_scl && !scl_i;
    assign w_phase_end = (r_cnt == CW'(ClkDiv - 1)) && !w_stretch;

    always_comb begin
        w_state_n    = r_state;
        w_q_n        = r_q;
        w_cnt_n      = r_cnt;
        w_bit_n      = r_bit;
        w_op_n       = r_op;
        w_data_n     = r_data;
        w_ack_n      = r_ack;
        w_shift_n    = r_shift;
        w_sample_n   = r_sample;
        w_scl_n      = r_scl;
        w_sda_n      = r_sda;
        w_ready_n    = r_ready;
        w_rsp_vld_n  = 1'b0;
        w_rsp_data_n = r_rsp_data;
        w_nack_n     = r_nack;
        w_busy_n     = r_busy;
        if (r_state == S_IDLE) begin
            if (cmd_valid_i && r_ready) begin
                w_op_n    = cmd_op_i;
                w_data_n  = cmd_data_i;
                w_ack_n   = cmd_ack_i;
                w_q_n     = 2'd0;
                w_cnt_n   = '0;
                w_bit_n   = 4'd0;
                w_ready_n = 1'b0;
                case (cmd_op_i)
                    OP_START: begin
                        w_state_n = S_START;
                        w_sda_n   = 1'b1;
                    end
                    OP_STOP: begin
                        w_state_n = S_STOP;
                        w_scl_n   = 1'b0;
                        w_sda_n   = 1'b0;
                    end
                    default: begin
                        w_state_n = S_BIT;
                        w_scl_n   = 1'b0;
                        w_sda_n   = bit_val(cmd_op_i, cmd_data_i, cmd_ack_i, 4'd0);
                    end
                endcase
            end
        end else if (w_stretch) begin
            w_cnt_n = '0;
        end else if (!w_phase_end) begin
            w_cnt_n = r_cnt + CW'(1);
        end else begin
            w_cnt_n = '0;
            w_q_n   = r_q + 2'd1;
            case (r_state)
                S_START: begin
                    case (r_q)
                        2'd0: w_scl_n = 1'b1;
                        2'd1: w_sda_n = 1'b0;
                        2'd2: w_scl_n = 1'b0;
                        default: begin
                            w_busy_n    = 1'b1;
                            w_state_n   = S_IDLE;
                            w_ready_n   = 1'b1;
                            w_rsp_vld_n = 1'b1;
                        end
                    endcase
                end
                S_BIT: begin
                    case (r_q)
                        2'd0: ;
                        2'd1: w_scl_n = 1'b1;
                        2'd2: begin
                            if (r_bit < 4'd8) w_shift_n = {r_shift[6:0], sda_i};
                            else              w_sample_n = sda_i;
                        end
                        default: begin
                            w_scl_n = 1'b0;
                            if (r_bit == 4'd8) begin
                                if (r_op == OP_WRITE) w_nack_n = r_sample;
                                if (r_op == OP_READ)  w_rsp_data_n = r_shift;
                                w_state_n   = S_IDLE;
                                w_ready_n   = 1'b1;
                                w_rsp_vld_n = 1'b1;
                            end else begin
                                w_bit_n = r_bit + 4'd1;
                                w_sda_n = bit_val(r_op, r_data, r_ack, r_bit + 4'd1);
                            end
                        end
                    endcase
                end
                S_STOP: begin
                    case (r_q)
                        2'd0: w_scl_n = 1'b1;
                        2'd1: w_sda_n = 1'b1;
                        2'd2: ;
                        default: begin
                            w_busy_n    = 1'b0;
                            w_state_n   = S_IDLE;
                            w_ready_n   = 1'b1;
                            w_rsp_vld_n = 1'b1;
                        end
                    endcase
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_q        <= 2'd0;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_op       <= 2'd0;
            r_data     <= 8'd0;
            r_ack      <= 1'b0;
            r_shift    <= 8'd0;
            r_sample   <= 1'b0;
            r_scl      <= 1'b1;
            r_sda      <= 1'b1;
            r_ready    <= 1'b1;
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= 8'd0;
            r_nack     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_q        <= w_q_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_op       <= w_op_n;
            r_data     <= w_data_n;
            r_ack      <= w_ack_n;
            r_shift    <= w_shift_n;
            r_sample   <= w_sample_n;
            r_scl      <= w_scl_n;
            r_sda      <= w_sda_n;
            r_ready    <= w_ready_n;
            r_rsp_vld  <= w_rsp_vld_n;
            r_rsp_data <= w_rsp_data_n;
            r_nack     <= w_nack_n;
            r_busy     <= w_busy_n;
        end
    end

    assign cmd_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_vld;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_nack_o  = r_nack;
    assign bus_busy_o  = r_busy;
    assign scl_o       = r_scl;
    assign sda_o       = r_sda;
endmodule

// File: tb/tb_i2c_host_ctrl.sv
// Directed bench for i2c_host_ctrl: wired-AND bus with a simple target (ACK, byte source, clock stretch).
module tb_i2c_host_ctrl;
    localparam int ClkDiv = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i = 2'd0;
    logic [7:0] cmd_data_i = 8'd0;
    logic       cmd_ack_i = 1'b0;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       rsp_nack_o;
    logic       bus_busy_o;
    logic       scl_o, sda_o;
    logic       tgt_scl = 1'b1;
    logic       tgt_sda = 1'b1;
    wire        scl_i = scl_o & tgt_scl;
    wire        sda_i = sda_o & tgt_sda;

    i2c_host_ctrl #(.ClkDiv(ClkDiv)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i), .cmd_ack_i(cmd_ack_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_nack_o(rsp_nack_o),
        .bus_busy_o(bus_busy_o),
        .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // bus monitor + target model, all state owned by this block
    int         tgt_mode = 0;      // 0 none, 1 ACK a write, 2 send tgt_byte
    logic [7:0] tgt_byte = 8'h00;
    int         stretch_rise = 0;  // rise number (1-based in command) that triggers a stretch
    int         base = 0;
    logic       rec [0:1023];
    int         rise_total = 0;
    int         srh_total = 0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         r = 0;
    int         st_left = 0;
    logic       b8_and = 1'b1, fell8 = 1'b0;
    logic [7:0] sh;
    logic       rose;

    always @(negedge clk) begin
        rose = scl_o && !prev_scl;
        if (rose) begin
            rec[rise_total % 1024] = sda_o;
            rise_total++;
        end
        if (sda_o && !prev_sda && scl_o && prev_scl) srh_total++;
        prev_scl = scl_o;
        prev_sda = sda_o;
        r = rise_total - base;
        if (rose && r == stretch_rise) begin
            tgt_scl = 1'b0;
            st_left = 20;
        end else if (st_left > 0) begin
            st_left--;
            if (st_left == 0) tgt_scl = 1'b1;
        end
        if (!scl_o) begin
            case (tgt_mode)
                1: tgt_sda = (r == 8) ? 1'b0 : 1'b1;
                2: begin
                    sh = tgt_byte << r;
                    tgt_sda = (r < 8) ? sh[7] : 1'b1;
                end
                default: tgt_sda = 1'b1;
            endcase
        end
        if (r < 8) begin
            b8_and = 1'b1;
            fell8 = 1'b0;
        end else begin
            if (r == 8 && !scl_o) fell8 = 1'b1;
            if (fell8 && (r == 8 || (r == 9 && scl_o))) b8_and = b8_and & sda_o;
        end
    end

    int srh_base = 0;

    // issue one command, wait for its response; lat = cycles from acceptance+1 to rsp_valid
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic ack,
                          output int lat, output int b);
        int n;
        @(negedge clk);
        cmd_op_i = op; cmd_data_i = d; cmd_ack_i = ack; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        base = rise_total;
        srh_base = srh_total;
        b = rise_total;
        n = 1;
        while (!rsp_valid_o && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n - 1;
    endtask

    function automatic logic [7:0] rec_byte(input int b);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v = {v[6:0], rec[(b + i) % 1024]};
        return v;
    endfunction

    int lat, b, pulses;

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("rst_scl", 32'(scl_o), 1);
        chk("rst_sda", 32'(sda_o), 1);
        chk("rst_ready", 32'(cmd_ready_o), 1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_busy", 32'(bus_busy_o), 0);

        // START
        do_cmd(2'd0, 8'h00, 1'b0, lat, b);
        chk("start_lat", 32'(lat), 32'(4 * ClkDiv));
        chk("start_busy", 32'(bus_busy_o), 1);
        chk("start_ready", 32'(cmd_ready_o), 1);

        // WRITE 0xA5 with ACK
        tgt_mode = 1;
        do_cmd(2'd2, 8'hA5, 1'b0, lat, b);
        chk("wr_a5_lat", 32'(lat), 144);
        chk("wr_a5_nack", 32'(rsp_nack_o), 0);
        chk("wr_a5_busy", 32'(bus_busy_o), 1);
        chk("wr_a5_bits", 32'(rec_byte(b)), 32'hA5);
        chk("wr_a5_rises", 32'(rise_total - b), 9);

        // WRITE 0x3C, no target
        tgt_mode = 0;
        do_cmd(2'd2, 8'h3C, 1'b0, lat, b);
        chk("wr_3c_nack", 32'(rsp_nack_o), 1);
        chk("wr_3c_b8_released", 32'(b8_and), 1);
        chk("wr_3c_bits", 32'(rec_byte(b)), 32'h3C);

        // READ 0x5A with NACK
        tgt_mode = 2; tgt_byte = 8'h5A;
        do_cmd(2'd3, 8'h00, 1'b0, lat, b);
        chk("rd_lat", 32'(lat), 144);
        chk("rd_data", 32'(rsp_data_o), 32'h5A);
        chk("rd_b8_nack", 32'(b8_and), 1);
        chk("rd_nack_held", 32'(rsp_nack_o), 1);

        // STOP
        tgt_mode = 0;
        do_cmd(2'd1, 8'h00, 1'b0, lat, b);
        chk("stop_lat", 32'(lat), 32'(4 * ClkDiv));
        chk("stop_busy", 32'(bus_busy_o), 0);
        chk("stop_sda_rise_scl_hi", 32'(srh_total - srh_base), 1);
        chk("stop_scl", 32'(scl_o), 1);
        chk("stop_sda", 32'(sda_o), 1);

        // clock stretch in bit 3 of WRITE 0xFF
        do_cmd(2'd0, 8'h00, 1'b0, lat, b);
        chk("start2_busy", 32'(bus_busy_o), 1);
        tgt_mode = 1; stretch_rise = 4;
        do_cmd(2'd2, 8'hFF, 1'b0, lat, b);
        stretch_rise = 0;
        chk("st_lat", 32'(lat), 164);
        chk("st_bits", 32'(rec_byte(b)), 32'hFF);
        chk("st_nack", 32'(rsp_nack_o), 0);
        chk("st_rdata_held", 32'(rsp_data_o), 32'h5A);

        // reset in the middle of a WRITE
        tgt_mode = 0;
        @(negedge clk);
        cmd_op_i = 2'd2; cmd_data_i = 8'h00; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        chk("abort_busy_ready", 32'(cmd_ready_o), 0);
        repeat (49) begin @(posedge clk); #1; end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("abort_scl", 32'(scl_o), 1);
        chk("abort_sda", 32'(sda_o), 1);
        chk("abort_ready", 32'(cmd_ready_o), 1);
        chk("abort_busy", 32'(bus_busy_o), 0);
        pulses = 0;
        repeat (200) begin
            if (rsp_valid_o) pulses++;
            @(posedge clk); #1;
        end
        chk("abort_no_rsp", 32'(pulses), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_host_ctrl.md
# i2c_host_ctrl

Synthesizable single-controller I2C host that drives an open-drain SCL/SDA pair from a byte-level command stream. It is the initiator end of the bus that the I2C DPI device models respond on. In simulation its `scl_o`/`sda_o` are wire-ANDed with the DPI model outputs. In hardware they drive pad enables. Supported: START/repeated START, STOP, byte write with ACK sampling, byte read with ACK/NACK generation, and target clock stretching. Multi-master arbitration is not supported.

## Interface
- `ClkDiv`, default 4: system cycles per quarter SCL period. Minimum 2. Counter width is `$clog2(ClkDiv)+1`.
- `clk_i` input 1: system clock.
- `rst_i` input 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `cmd_valid_i` input 1: command offered.
- `cmd_ready_o` output 1: controller idle and able to accept a command.
- `cmd_op_i` input 2: 0 = START, 1 = STOP, 2 = WRITE, 3 = READ.
- `cmd_data_i` input 8: byte to transmit for WRITE, sent MSB first.
- `cmd_ack_i` input 1: READ only. 1 = drive ACK (SDA low) in the 9th bit; 0 = NACK.
- `rsp_valid_o` output 1: one-cycle pulse when a command completes (all ops).
- `rsp_data_o` output 8: byte received by READ. Holds its value until the next READ completes.
- `rsp_nack_o` output 1: WRITE only; target NACKed. Holds until the next WRITE completes.
- `bus_busy_o` output 1: set when START completes, cleared when STOP completes.
- `scl_i` input 1: observed SCL line (wired-AND).
- `sda_i` input 1: observed SDA line.
- `scl_o` output 1: SCL drive. 0 = pull low, 1 = release.
- `sda_o` output 1: SDA drive. 0 = pull low, 1 = release.

## Operation
- FSM states: IDLE, START, BIT, STOP.
- Each non-IDLE step is a sequence of quarter phases Q0..Q3, each lasting ClkDiv cycles.
- Every output is a register, so there is no combinational path from `scl_i`/`sda_i` to `scl_o`/`sda_o`.
- Command handshake:
  - A command is accepted when `cmd_valid_i && cmd_ready_o`.
  - `cmd_ready_o` is 1 only in IDLE.
  - Op, data and ack are captured at acceptance.
  - Inputs are ignored while not ready.
- START (also repeated START):
  - Q0: release SDA.
  - Q1: release SCL, with stretch wait.
  - Q2: pull SDA low.
  - Q3: pull SCL low.
  - From an idle bus Q0/Q1 are no-ops, so the START condition is SDA falling while SCL is high.
- BIT (one bit), 9 bits per WRITE/READ:
  - Q0: pull SCL low, then set SDA.
  - Q1: hold.
  - Q2: release SCL, with stretch wait; sample `sda_i` on the last cycle of Q2.
  - Q3: hold SCL high.
- WRITE:
  - Bits 0–7 drive `cmd_data_i[7-i]`.
  - Bit 8 releases SDA; the sampled value goes to `rsp_nack_o`.
- READ:
  - Bits 0–7 release SDA and shift the sampled bits into a register, MSB first.
  - Bit 8 drives `sda_o = !cmd_ack_i`.
- STOP:
  - Q0: pull SCL low, pull SDA low.
  - Q1: release SCL, with stretch wait.
  - Q2: release SDA.
  - Q3: hold; the bus is free.
- Clock stretch: in any phase where SCL is released, the phase counter holds at 0 while `scl_i == 0`. There is no timeout; reset is the only escape.
- Command ordering is not checked:
  - WRITE/READ/STOP are executed from any bus state.
  - WRITE/READ without a prior START still run the bit sequence.
- After completion the FSM returns to IDLE. SCL stays low after WRITE/READ and both lines are released after STOP.

## Timing
- Reset values (from the cycle after `rst_i` is sampled high):
  - `scl_o = 1`, `sda_o = 1`, `cmd_ready_o = 1`.
  - `rsp_valid_o = 0`, `rsp_data_o = 0`, `rsp_nack_o = 0`, `bus_busy_o = 0`.
  - State is IDLE and all counters are 0.
- Reset mid-operation aborts immediately. Both lines are released the next cycle with no STOP generated.
- Completion latency: a command accepted at clock edge N gives phase Q0 starting at cycle N+1. `rsp_valid_o` is high exactly in cycle N + P·ClkDiv + S + 1, where:
  - P = 4 for START/STOP, 36 for WRITE/READ.
  - S = total stretch cycles.
- In the `rsp_valid_o` cycle:
  - `cmd_ready_o` is 1, so back-to-back acceptance is possible with no idle quarter phase.
  - `rsp_data_o`, `rsp_nack_o` and `bus_busy_o` are already updated.
- SCL period with no stretch is 4·ClkDiv cycles, with 50% duty.
- SDA changes only in Q0 while SCL is low, except in START Q0/Q2 and STOP Q2.

## Test plan
- Reset: `rst_i` held for 3 cycles, then released → `scl_o = sda_o = 1`, `cmd_ready_o = 1`, `rsp_valid_o = 0`, `bus_busy_o = 0`.
- START then WRITE 0xA5, target ACKs, ClkDiv = 4:
  - SDA values at the 8 SCL rising edges are 1,0,1,0,0,1,0,1.
  - `rsp_valid_o` arrives 144 cycles after WRITE acceptance+1, with `rsp_nack_o = 0` and `bus_busy_o = 1`.
- WRITE 0x3C with no target (`sda_i` only follows `sda_o`) → `rsp_nack_o = 1`, and SDA is released throughout the 9th bit.
- READ with `cmd_ack_i = 0`, target sends 0x5A, then STOP:
  - `rsp_data_o = 0x5A`, and `sda_o = 1` in bit 8.
  - During STOP, SDA rises while SCL is high.
  - `bus_busy_o = 0` at the STOP response.
- Clock stretch: target holds `scl_i` low for 20 cycles in bit 3 of WRITE 0xFF → completion latency 144 + 20, and the byte is still received correctly.
- Reset asserted at cycle 50 of a WRITE → next cycle `scl_o = sda_o = 1`, `cmd_ready_o = 1`, and no `rsp_valid_o` pulse.
